// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one combinational ULA between two requesters.
// Round-robin arbitration picks at most one operation per cycle. The
// granted operands drive the shared ULA, and the result is captured in a
// per-requester response register with one cycle of latency.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready/op/in1/in2/shamt request channel of requester N (N=0,1)
//   rspN_valid/ready/result/zero      registered response channel of requester N
//   alu_op/in1/in2/shamt              operands driven to the shared ULA
//   alu_result/alu_zero               combinational return from the shared ULA
module ula_arbiter #(
   parameter int unsigned RR_INIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_in1,
   input  logic [31:0] req0_in2,
   input  logic [4:0]  req0_shamt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_in1,
   input  logic [31:0] req1_in2,
   input  logic [4:0]  req1_shamt,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_zero,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_zero,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   input  logic        alu_zero
);

   localparam logic [3:0] ALU_ADD = 4'd0;

   logic        r_prio;
   logic        r_rsp0_valid;
   logic [31:0] r_rsp0_result;
   logic        r_rsp0_zero;
   logic        r_rsp1_valid;
   logic [31:0] r_rsp1_result;
   logic        r_rsp1_zero;

   logic w_elig0;
   logic w_elig1;
   logic w_gnt0;
   logic w_gnt1;

   // A requester may issue only if its response slot is empty or being drained now.
   assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
   assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);

   // Grant is suppressed during reset so no operation is performed in that cycle.
   assign w_gnt0 = !rst && w_elig0 && (!w_elig1 || (r_prio == 1'b0));
   assign w_gnt1 = !rst && w_elig1 && (!w_elig0 || (r_prio == 1'b1));

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Operand mux towards the shared ULA; idle values when nobody is granted.
   always_comb begin
      alu_op    = ALU_ADD;
      alu_in1   = 32'd0;
      alu_in2   = 32'd0;
      alu_shamt = 5'd0;
      if (w_gnt0) begin
         alu_op    = req0_op;
         alu_in1   = req0_in1;
         alu_in2   = req0_in2;
         alu_shamt = req0_shamt;
      end else if (w_gnt1) begin
         alu_op    = req1_op;
         alu_in1   = req1_in1;
         alu_in2   = req1_in2;
         alu_shamt = req1_shamt;
      end
   end

   // Priority pointer moves to the loser only when a grant happens.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio <= 1'(RR_INIT);
      end else if (w_gnt0) begin
         r_prio <= 1'b1;
      end else if (w_gnt1) begin
         r_prio <= 1'b0;
      end
   end

   // Response register 0: load on grant, clear valid on consume, data holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp0_valid  <= 1'b0;
         r_rsp0_result <= 32'd0;
         r_rsp0_zero   <= 1'b0;
      end else if (w_gnt0) begin
         r_rsp0_valid  <= 1'b1;
         r_rsp0_result <= alu_result;
         r_rsp0_zero   <= alu_zero;
      end else if (rsp0_ready) begin
         r_rsp0_valid  <= 1'b0;
      end
   end

   // Response register 1: same behaviour as register 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp1_valid  <= 1'b0;
         r_rsp1_result <= 32'd0;
         r_rsp1_zero   <= 1'b0;
      end else if (w_gnt1) begin
         r_rsp1_valid  <= 1'b1;
         r_rsp1_result <= alu_result;
         r_rsp1_zero   <= alu_zero;
      end else if (rsp1_ready) begin
         r_rsp1_valid  <= 1'b0;
      end
   end

   assign rsp0_valid  = r_rsp0_valid;
   assign rsp0_result = r_rsp0_result;
   assign rsp0_zero   = r_rsp0_zero;
   assign rsp1_valid  = r_rsp1_valid;
   assign rsp1_result = r_rsp1_result;
   assign rsp1_zero   = r_rsp1_zero;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed bench for ula_arbiter with a small ULA model
// standing in for the shared ULA instance.
module tb_ula_arbiter;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLL = 4'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
   logic [31:0] req0_in1 = 32'd0, req0_in2 = 32'd0, req1_in1 = 32'd0, req1_in2 = 32'd0;
   logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp1_zero;
   logic [3:0]  alu_op;
   logic [31:0] alu_in1, alu_in2;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result;
   logic        alu_zero;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   ula_arbiter #(.RR_INIT(0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_shamt(req0_shamt),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_shamt(req1_shamt),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // Shared ULA model (subset of operations used here).
   always_comb begin
      case (alu_op)
         ALU_ADD: alu_result = alu_in1 + alu_in2;
         ALU_SUB: alu_result = alu_in1 - alu_in2;
         ALU_OR:  alu_result = alu_in1 | alu_in2;
         ALU_SLL: alu_result = alu_in2 << alu_shamt;
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req0_op = ALU_SUB; req0_in1 = 32'd3; req0_in2 = 32'd1;
      req1_valid = 1'b1; req1_op = ALU_OR;  req1_in1 = 32'd8; req1_in2 = 32'd2;
      #1;
      n_total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      n_total++;
      if (alu_op !== ALU_ADD || alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_shamt !== 5'd0) begin
         n_bad++; $display("FAIL reset_alu_idle: got op=%0d in1=%0h in2=%0h sh=%0d want 0/0/0/0",
                           alu_op, alu_in1, alu_in2, alu_shamt);
      end
      tick();
      idle_inputs();
      rst = 1'b0;
      #1;
      n_total++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_result !== 32'd0 ||
          rsp1_result !== 32'd0 || rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin
         n_bad++; $display("FAIL reset_rsp: got v=%b%b r0=%0h r1=%0h z=%b%b want all 0",
                           rsp0_valid, rsp1_valid, rsp0_result, rsp1_result, rsp0_zero, rsp1_zero);
      end
   endtask

   task automatic test_single();
      do_reset();
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = 32'd5; req0_in2 = 32'd7; req0_shamt = 5'd0;
      #1;
      n_total++;
      if (req0_ready !== 1'b1 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin
         n_bad++; $display("FAIL single_grant: got rdy=%b in1=%0d in2=%0d want 1/5/7",
                           req0_ready, alu_in1, alu_in2);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      n_total++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12 || rsp0_zero !== 1'b0) begin
         n_bad++; $display("FAIL single_rsp: got v=%b res=%0d z=%b want 1/12/0",
                           rsp0_valid, rsp0_result, rsp0_zero);
      end
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      #1;
      n_total++;
      if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd12) begin
         n_bad++; $display("FAIL single_consume: got v=%b res=%0d want 0/12", rsp0_valid, rsp0_result);
      end
      // Consume request on an empty slot is ignored.
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      #1;
      n_total++;
      if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd12) begin
         n_bad++; $display("FAIL single_ready_empty: got v=%b res=%0d want 0/12", rsp0_valid, rsp0_result);
      end
   endtask

   task automatic test_alternate();
      logic [1:0] exp_seq [4];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = ALU_SUB; req0_in1 = 32'd9;    req0_in2 = 32'd9;
      req1_valid = 1'b1; req1_op = ALU_OR;  req1_in1 = 32'hF0;   req1_in2 = 32'h0F;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_total++;
         if ({req1_ready, req0_ready} !== exp_seq[i]) begin
            n_bad++; $display("FAIL alt_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, exp_seq[i]);
         end
         tick();
      end
      idle_inputs();
      #1;
      n_total++;
      if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd0 || rsp0_zero !== 1'b1) begin
         n_bad++; $display("FAIL alt_rsp0: got v=%b res=%0h z=%b want 0/0/1", rsp0_valid, rsp0_result, rsp0_zero);
      end
      n_total++;
      if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFF || rsp1_zero !== 1'b0) begin
         n_bad++; $display("FAIL alt_rsp1: got v=%b res=%0h z=%b want 1/ff/0", rsp1_valid, rsp1_result, rsp1_zero);
      end
   endtask

   // Entered with rsp1 holding 0xFF; pointer favours requester 0.
   task automatic test_blocked();
      rsp0_ready = 1'b1; rsp1_ready = 1'b0;
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = 32'd1; req0_in2 = 32'd1;
      req1_valid = 1'b1; req1_op = ALU_ADD; req1_in1 = 32'd2; req1_in2 = 32'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL blocked_grant[%0d]: got r0=%b r1=%b want 1/0", i, req0_ready, req1_ready);
         end
         tick();
         n_total++;
         if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFF) begin
            n_bad++; $display("FAIL blocked_rsp1_hold[%0d]: got v=%b res=%0h want 1/ff", i, rsp1_valid, rsp1_result);
         end
      end
      rsp1_ready = 1'b1;
      #1;
      n_total++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || alu_in1 !== 32'd2) begin
         n_bad++; $display("FAIL unblock_grant: got r0=%b r1=%b in1=%0d want 0/1/2", req0_ready, req1_ready, alu_in1);
      end
      tick();
      idle_inputs();
      #1;
      n_total++;
      if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd4 || rsp0_result !== 32'd2) begin
         n_bad++; $display("FAIL unblock_rsp: got v1=%b r1=%0d r0=%0d want 1/4/2", rsp1_valid, rsp1_result, rsp0_result);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      do_reset();
      rsp0_ready = 1'b1;
      req0_valid = 1'b1; req0_op = ALU_SLL; req0_in1 = 32'd0; req0_in2 = 32'd1;
      for (int k = 0; k < 32; k++) begin
         req0_shamt = 5'(k);
         #1;
         n_total++;
         if (req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_grant[%0d]: got %b want 1", k, req0_ready);
         end
         tick();
         exp = 32'd1 << k;
         n_total++;
         if (rsp0_valid !== 1'b1 || rsp0_result !== exp) begin
            n_bad++; $display("FAIL b2b_rsp[%0d]: got v=%b res=%0h want 1/%0h", k, rsp0_valid, rsp0_result, exp);
         end
      end
      idle_inputs();
   endtask

   task automatic test_idle();
      do_reset();
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = 32'd3; req0_in2 = 32'd4;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         req0_in1 = 32'hDEAD; req1_in2 = 32'hBEEF;
         #1;
         n_total++;
         if (alu_op !== ALU_ADD || alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_shamt !== 5'd0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL idle_alu[%0d]: got op=%0d in1=%0h in2=%0h rdy=%b%b want 0/0/0/00",
                              i, alu_op, alu_in1, alu_in2, req1_ready, req0_ready);
         end
         tick();
         n_total++;
         if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7 || rsp1_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold[%0d]: got v0=%b r0=%0d v1=%b want 1/7/0", i, rsp0_valid, rsp0_result, rsp1_valid);
         end
      end
      // Pointer should still favour requester 1 after the idle stretch.
      rsp0_ready = 1'b1;
      req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd1;
      req1_valid = 1'b1; req1_op = ALU_ADD; req1_in1 = 32'd10; req1_in2 = 32'd20;
      #1;
      n_total++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         n_bad++; $display("FAIL idle_pointer: got r0=%b r1=%b want 0/1", req0_ready, req1_ready);
      end
      tick();
      idle_inputs();
      #1;
      n_total++;
      if (rsp1_result !== 32'd30 || rsp0_valid !== 1'b0 || rsp0_result !== 32'd7) begin
         n_bad++; $display("FAIL idle_after: got r1=%0d v0=%b r0=%0d want 30/0/7", rsp1_result, rsp0_valid, rsp0_result);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req1_valid = 1'b1; req1_op = ALU_ADD; req1_in1 = 32'd1; req1_in2 = 32'd1;
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = 32'd2; req0_in2 = 32'd2;
      tick();
      // Pointer now favours 1 and rsp1 holds 2; reset with both requesting.
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req1_valid = 1'b1; req1_in1 = 32'd5; req1_in2 = 32'd5;
      rst = 1'b1;
      #1;
      n_total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_in1 !== 32'd0) begin
         n_bad++; $display("FAIL midrst_grant: got rdy=%b%b in1=%0d want 00/0", req1_ready, req0_ready, alu_in1);
      end
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_result !== 32'd0 || rsp1_result !== 32'd0 ||
          rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin
         n_bad++; $display("FAIL midrst_rsp: got v=%b%b r0=%0h r1=%0h z=%b%b want all 0",
                           rsp1_valid, rsp0_valid, rsp0_result, rsp1_result, rsp1_zero, rsp0_zero);
      end
      n_total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_bad++; $display("FAIL midrst_pointer: got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_blocked();
      test_back_to_back();
      test_idle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, index of the requester holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-006 reqN_op  input  4  operation code from defines.vh (`ALU_ADD ... `ALU_JR).
REQ-007 reqN_in1, reqN_in2  input  32  operands.
REQ-008 reqN_shamt  input  5  shift amount.
REQ-009 rspN_valid  output  1  response register of requester N holds a result.
REQ-010 rspN_ready  input  1  requester N consumes its response this cycle.
REQ-011 rspN_result  output  32  registered ALU result.
REQ-012 rspN_zero  output  1  registered ALU zero flag.
REQ-013 alu_op  output  4, alu_in1/alu_in2  output  32, alu_shamt  output  5: drive the shared ula instance.
REQ-014 alu_result  input  32, alu_zero  input  1: combinational return from the shared ula.

Function
REQ-015 Requester N is eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-016 At most one grant per cycle; reqN_ready=1 exactly in the cycle N is granted (combinational, no dependence on alu_result).
REQ-017 One eligible requester: granted. Both eligible: requester indicated by priority pointer granted.
REQ-018 Priority pointer updates only on a grant, to the non-granted index; unchanged in idle cycles.
REQ-019 Granted requester's op/in1/in2/shamt drive alu_* in the grant cycle; no grant: alu_op=`ALU_ADD, alu_in1=alu_in2=0, alu_shamt=0.
REQ-020 Latency 1: grant at edge k loads rspN_result/rspN_zero from alu_result/alu_zero and sets rspN_valid=1 after edge k.
REQ-021 Grant and rspN_ready in same cycle: old response consumed, new response loaded, rspN_valid stays 1 (full throughput, one op/cycle per requester when alone).
REQ-022 rspN_ready=1 with no new grant for N: rspN_valid cleared next edge; rspN_result/rspN_zero hold last value.
REQ-023 rspN_ready while rspN_valid=0: ignored.
REQ-024 Response of one requester never modified by a grant to the other.
REQ-025 Requester obligation: reqN fields stable while reqN_valid=1 and reqN_ready=0; arbiter does not latch requests.
REQ-026 Fairness: a continuously eligible requester is granted within 2 cycles.
REQ-027 Response register full and rspN_ready=0: requester N not eligible, reqN_ready=0; other requester may be granted.

Reset
REQ-028 While rst=1: req0_ready=req1_ready=0, no grant, alu_* at idle values.
REQ-029 After reset edge: rspN_valid=0, rspN_result=0, rspN_zero=0, pointer=RR_INIT.
REQ-030 Reset mid-operation discards any response in flight; a grant asserted in the reset cycle is not performed.

Verification
REQ-031 Single req0: op=`ALU_ADD, in1=5, in2=7 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
REQ-032 Both valid after reset, RR_INIT=0, rsp_ready held 1: req0 `ALU_SUB 9-9, req1 `ALU_OR 0xF0|0x0F -> grants alternate 0,1,0,1; rsp0_result=0, rsp0_zero=1; rsp1_result=0xFF.
REQ-033 rsp1_valid=1, rsp1_ready=0, req1 and req0 valid -> req1_ready=0 every cycle, req0 granted every cycle; raise rsp1_ready -> req1 granted that cycle.
REQ-034 req0 back-to-back `ALU_SLL in2=1 shamt=0..31, rsp0_ready=1 -> one response per cycle, result 1<<k, rsp0_valid never drops.
REQ-035 rst asserted in cycle of grant with rsp1_valid=1 -> next cycle rsp0_valid=rsp1_valid=0, results 0, pointer=RR_INIT.
REQ-036 Idle cycles (no valid) -> alu_op=`ALU_ADD, alu_in1=alu_in2=0, pointer unchanged, responses held.
